// File: rtl/result_packer_pkg.sv
// rtl/result_packer_pkg.sv - shared widths and FSM encoding for the result packer
package result_packer_pkg;

    localparam int RESULT_W  = 16;
    localparam int PIPE_W    = 32;
    localparam int BURST_LEN = 256;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAD   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/result_packer.sv
// rtl/result_packer.sv - packs 16-bit engine results into 32-bit FIFO words, low half first
module result_packer
    import result_packer_pkg::*;
#(
    parameter int DATA_W = RESULT_W,
    parameter int OUT_W  = PIPE_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [OUT_W-1:0]  fifo_din,
    output logic              flush_done,
    output logic [CNT_W-1:0]  word_count,
    output logic              overflow
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_lo;
    logic               r_half;
    logic [OUT_W-1:0]   r_out_word;
    logic               r_pend;
    logic [CNT_W-1:0]   r_word_count;
    logic               r_overflow;

    logic               w_write;
    logic               w_accept;
    logic               w_pair;
    logic               w_pad_load;
    logic               w_flush_done;

    // No write may leave in the reset cycle even if a word is still pending.
    assign w_write  = r_pend & ~fifo_full & ~rst;
    assign in_ready = (r_state == ST_RUN) & (~r_half | ~r_pend | ~fifo_full) & ~rst;
    assign w_accept = in_valid & in_ready;
    assign w_pair   = w_accept & r_half;

    always_comb begin
        w_state_nxt  = r_state;
        w_pad_load   = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (flush) begin
                    w_state_nxt = ST_PAD;
                end
            end
            ST_PAD: begin
                if (!r_half) begin
                    w_state_nxt = ST_DRAIN;
                end else if (!r_pend || w_write) begin
                    w_pad_load  = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_pend) begin
                    w_flush_done = 1'b1;
                    w_state_nxt  = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_lo         <= '0;
            r_half       <= 1'b0;
            r_out_word   <= '0;
            r_pend       <= 1'b0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept && !r_half) begin
                r_lo   <= in_data;
                r_half <= 1'b1;
            end

            // A reload in the same cycle as a write keeps the skid entry occupied.
            if (w_pair) begin
                r_out_word <= {in_data, r_lo};
                r_pend     <= 1'b1;
                r_half     <= 1'b0;
            end else if (w_pad_load) begin
                r_out_word <= {{(OUT_W-DATA_W){1'b0}}, r_lo};
                r_pend     <= 1'b1;
                r_half     <= 1'b0;
            end else if (w_write) begin
                r_pend <= 1'b0;
            end

            if (w_write) begin
                r_word_count <= r_word_count + CNT_W'(1);
            end

            if (in_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign fifo_wr_en = w_write;
    assign fifo_din   = r_out_word;
    assign flush_done = w_flush_done & ~rst;
    assign word_count = r_word_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_result_packer.sv
// tb/tb_result_packer.sv - scoreboard bench for result_packer
module tb_result_packer;

    localparam int TB_CNT_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [15:0]         in_data;
    logic                in_ready;
    logic                flush;
    logic                fifo_full;
    logic                fifo_wr_en;
    logic [31:0]         fifo_din;
    logic                flush_done;
    logic [TB_CNT_W-1:0] word_count;
    logic                overflow;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          last_wr_cyc = -1;
    int          done_cyc = -1;
    logic [31:0] exp_q[$];

    result_packer #(.DATA_W(16), .OUT_W(32), .CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .flush_done (flush_done),
        .word_count (word_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            logic [31:0] exp_word;
            last_wr_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL fifo_write_unexpected actual=%h required=no write", fifo_din);
            end else begin
                exp_word = exp_q.pop_front();
                if (fifo_din !== exp_word) begin
                    failures++;
                    $display("FAIL fifo_word actual=%h required=%h", fifo_din, exp_word);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        check("queue_drained_before_reset", exp_q.size(), 0);
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        fifo_full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (flush_done === 1'b1) begin
                lat = i;
                done_cyc = cyc;
                break;
            end
        end
        check(name, lat, exp_lat);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        fifo_full = 1'b0;
        tick();
        @(negedge clk);
        check("reset_wr_en", fifo_wr_en, 0);
        check("reset_din", fifo_din, 0);
        check("reset_flush_done", flush_done, 0);
        check("reset_word_count", word_count, 0);
        check("reset_overflow", overflow, 0);
        check("reset_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;

        // Back-to-back stream of four samples.
        exp_q.push_back(32'h0002_0001);
        exp_q.push_back(32'h0004_0003);
        send(16'h0001);
        in_valid = 1'b1;
        in_data  = 16'h0002;
        @(posedge clk);
        @(negedge clk);
        check("pair_latency_wr_en", fifo_wr_en, 1);
        send(16'h0003);
        send(16'h0004);
        tick();
        tick();
        @(negedge clk);
        check("stream4_word_count", word_count, 2);
        check("stream4_overflow", overflow, 0);

        // Odd sample padded on flush.
        do_reset();
        exp_q.push_back(32'hBBBB_AAAA);
        exp_q.push_back(32'h0000_CCCC);
        send(16'hAAAA);
        send(16'hBBBB);
        send(16'hCCCC);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_done("flush_odd_done_latency", 3);
        check("flush_done_after_last_write", done_cyc - last_wr_cyc, 1);
        check("flush_odd_word_count", word_count, 2);

        // Full FIFO: hold one word plus one half, refuse the fourth.
        do_reset();
        fifo_full = 1'b1;
        exp_q.push_back(32'h2222_1111);
        exp_q.push_back(32'h5555_3333);
        send(16'h1111);
        send(16'h2222);
        send(16'h3333);
        in_valid = 1'b1;
        in_data  = 16'h4444;
        @(negedge clk);
        check("full_fourth_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("full_overflow", overflow, 1);
        check("full_no_write_count", word_count, 0);
        tick();
        fifo_full = 1'b0;
        tick();
        tick();
        send(16'h5555);
        tick();
        tick();
        @(negedge clk);
        check("full_release_word_count", word_count, 2);
        check("overflow_sticky", overflow, 1);

        // Flush coincident with an odd sample, then an empty flush.
        do_reset();
        exp_q.push_back(32'h0000_1234);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        wait_done("flush_same_cycle_latency", 3);
        tick();
        check("flush_same_cycle_count", word_count, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_done("flush_empty_latency", 2);
        tick();
        check("flush_empty_count", word_count, 1);

        // Reset with half and pend both set discards everything.
        do_reset();
        send(16'hAAAA);
        fifo_full = 1'b1;
        send(16'hBBBB);
        send(16'hCCCC);
        rst       = 1'b1;
        fifo_full = 1'b0;
        @(negedge clk);
        check("reset_cycle_wr_en", fifo_wr_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_din", fifo_din, 0);
        check("midreset_wr_en", fifo_wr_en, 0);
        check("midreset_word_count", word_count, 0);
        check("midreset_in_ready", in_ready, 1);
        exp_q.push_back(32'h0006_0005);
        send(16'h0005);
        send(16'h0006);
        tick();
        tick();
        check("after_reset_count", word_count, 1);

        // Counter wrap: 2^TB_CNT_W + 1 words leaves a count of 1.
        do_reset();
        for (int k = 0; k < (1 << TB_CNT_W) + 1; k++) begin
            logic [15:0] lo_v;
            lo_v = k[15:0];
            exp_q.push_back({~lo_v, lo_v});
            send(lo_v);
            send(~lo_v);
        end
        tick();
        tick();
        tick();
        @(negedge clk);
        check("word_count_wrap", word_count, 1);

        tick();
        check("queue_drained_final", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
